// File: rtl/libstf_pkg.sv
// libstf: shared stream-framework types and helpers.
//   VADDR_BITS      - virtual address width
//   vaddress_t      - virtual address / region length
//   data32_t        - 32-bit data word (request sizes)
//   stf_chunk_bytes - largest read starting at addr that neither exceeds
//                     remaining nor crosses a max_bytes-aligned boundary
package libstf;

    localparam int VADDR_BITS = 48;

    typedef logic [VADDR_BITS-1:0] vaddress_t;
    typedef logic [31:0]           data32_t;

    // max_bytes must be a power of two; the room to the next boundary is
    // derived with a mask rather than a modulo.
    function automatic vaddress_t stf_chunk_bytes(input vaddress_t addr,
                                                  input vaddress_t remaining,
                                                  input vaddress_t max_bytes);
        vaddress_t room;
        room = max_bytes - (addr & (max_bytes - vaddress_t'(1)));
        return (remaining < room) ? remaining : room;
    endfunction

endpackage

// File: rtl/mem_read_config_i.sv
// Read request configuration port of the memory read DMA.
//   vaddr/size - read request, valid/ready handshake
//   modport m: requester side, modport s: DMA side
interface mem_read_config_i
    import libstf::*;
(
    input logic clk,
    input logic rst_n
);
    vaddress_t vaddr;
    data32_t   size;
    logic      valid;
    logic      ready;

    modport m (output vaddr, output size, output valid, input ready);
    modport s (input vaddr, input size, input valid, output ready);

    // A request offered but not taken stays put until it is taken.
    a_rd_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (valid && !ready) |=> (!rst_n || (valid && $stable(vaddr) && $stable(size))));

endinterface

// File: rtl/stream_buffer_link_i.sv
// Region token link from the stream buffer writer to a reader.
//   vaddr/size/last - region descriptor, valid/ready handshake
//   modport m: writer side, modport s: reader side
interface stream_buffer_link_i
    import libstf::*;
(
    input logic clk,
    input logic rst_n
);
    vaddress_t vaddr;
    vaddress_t size;
    logic      last;
    logic      valid;
    logic      ready;

    modport m (output vaddr, output size, output last, output valid, input ready);
    modport s (input vaddr, input size, input last, input valid, output ready);

    // A token offered but not taken stays put until it is taken.
    a_link_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (valid && !ready) |=> (!rst_n || (valid && $stable(vaddr) && $stable(size) && $stable(last))));

endinterface

// File: rtl/stream_buffer_read_issuer.sv
// stream_buffer_read_issuer
// Turns each completed region token from the stream buffer writer into a
// series of DMA read requests, each at most MAX_READ_BYTES long and never
// crossing a MAX_READ_BYTES-aligned boundary.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   link       - region tokens {vaddr, size, last} in (valid/ready)
//   rd_cfg     - read requests {vaddr, size} out (valid/ready)
//   busy       - a token is held and chunks are still pending
//   done       - one-cycle pulse after the last token of a stream completes
// MAX_READ_BYTES must be a power of two in [64, 2^31].
module stream_buffer_read_issuer
    import libstf::*;
#(
    parameter longint unsigned MAX_READ_BYTES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_buffer_link_i.s       link,
    mem_read_config_i.m          rd_cfg,
    output logic                 busy,
    output logic                 done
);

    localparam vaddress_t MAX_V = vaddress_t'(MAX_READ_BYTES);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t    state, state_nxt;
    vaddress_t cur_addr;
    vaddress_t remaining;
    logic      last_q;
    logic      done_nxt;
    logic      load;
    logic      advance;
    logic      link_hs;
    vaddress_t chunk;

    // Computed purely from registers, so the request stays stable while
    // the DMA stalls.
    assign chunk = stf_chunk_bytes(cur_addr, remaining, MAX_V);

    assign link.ready   = rst_n && (state == IDLE);
    assign link_hs      = link.valid && link.ready;
    assign rd_cfg.valid = (state == ISSUE);
    assign rd_cfg.vaddr = cur_addr;
    // chunk <= MAX_READ_BYTES <= 2^31, so it always fits.
    assign rd_cfg.size  = data32_t'(chunk);
    assign busy         = (state == ISSUE);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (link_hs) begin
                    if (link.size != '0) begin
                        load      = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        // Empty region: nothing to read, but it may still
                        // terminate the stream.
                        done_nxt = link.last;
                    end
                end
            end
            ISSUE: begin
                if (rd_cfg.ready) begin
                    advance = 1'b1;
                    if (remaining == chunk) begin
                        state_nxt = IDLE;
                        done_nxt  = last_q;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Datapath needs no reset: it is only observed in ISSUE, which is
    // entered through a load.
    always_ff @(posedge clk) begin
        if (load) begin
            cur_addr  <= link.vaddr;
            remaining <= link.size;
            last_q    <= link.last;
        end else if (advance) begin
            cur_addr  <= cur_addr + chunk;
            remaining <= remaining - chunk;
        end
    end

    a_chunk_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ISSUE) |-> (chunk != '0));

    a_chunk_max: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ISSUE) |-> (chunk <= MAX_V));

    a_no_cross: assert property (@(posedge clk) disable iff (!rst_n)
        (state == ISSUE) |-> (((cur_addr & (MAX_V - vaddress_t'(1))) + chunk) <= MAX_V));

endmodule

// File: tb/tb_stream_buffer_read_issuer.sv
module tb_stream_buffer_read_issuer;
    import libstf::*;

    localparam longint unsigned MAXB = 4096;

    logic clk;
    logic rst_n;
    logic busy;
    logic done;

    stream_buffer_link_i link_if (.clk(clk), .rst_n(rst_n));
    mem_read_config_i    rd_if   (.clk(clk), .rst_n(rst_n));

    stream_buffer_read_issuer #(.MAX_READ_BYTES(MAXB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .link   (link_if),
        .rd_cfg (rd_if),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint unsigned a;
        longint unsigned s;
    } chunk_t;

    chunk_t mon_q[$];
    int     done_cnt = 0;

    // Log every accepted request and every done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_if.valid && rd_if.ready)
                mon_q.push_back('{a: longint'(rd_if.vaddr), s: longint'(rd_if.size)});
            if (done)
                done_cnt++;
        end
    end

    int   checks   = 0;
    int   failures = 0;
    logic rand_rdy = 1'b0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy)
            rd_if.ready = ($urandom_range(0, 3) != 0);
    endtask

    // Returns in the cycle after the accepting edge.
    task automatic send_token(input longint unsigned va, input longint unsigned sz, input logic lst);
        logic hs;
        hs = 1'b0;
        link_if.vaddr = vaddress_t'(va);
        link_if.size  = vaddress_t'(sz);
        link_if.last  = lst;
        link_if.valid = 1'b1;
        for (int k = 0; k < 5000 && !hs; k++) begin
            @(negedge clk);
            hs = link_if.ready;
            tick();
        end
        link_if.valid = 1'b0;
        if (!hs)
            chk("send_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 5000 && busy; k++)
            tick();
        if (busy)
            chk("idle_timeout", 1, 0);
        tick();
    endtask

    typedef struct {
        longint unsigned va;
        longint unsigned sz;
        logic            lst;
        int              n;
        longint unsigned first_sz;
        longint unsigned last_sz;
        int              dones;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base_q, base_d;
        longint unsigned a, r, bnd, c;
        chunk_t exp_q[$];
        int exp_done;

        vecs[0] = '{'h1000, 8192,   1'b0, 2, 4096, 4096, 0};
        vecs[1] = '{'h0F00, 'h1200, 1'b1, 3, 256,  256,  1};
        vecs[2] = '{'h0FFF, 1,      1'b1, 1, 1,    1,    1};
        vecs[3] = '{'h0FFF, 2,      1'b0, 2, 1,    1,    0};
        vecs[4] = '{'h3000, 4096,   1'b1, 1, 4096, 4096, 1};
        vecs[5] = '{'h3001, 4095,   1'b0, 1, 4095, 4095, 0};
        vecs[6] = '{'h0000, 0,      1'b1, 0, 0,    0,    1};
        vecs[7] = '{'h7FF0, 'h20,   1'b0, 2, 16,   16,   0};

        rst_n         = 1'b0;
        link_if.valid = 1'b0;
        link_if.vaddr = '0;
        link_if.size  = '0;
        link_if.last  = 1'b0;
        rd_if.ready   = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_if.valid, 0);
        chk("rst_link_ready", link_if.ready, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_link_ready", link_if.ready, 1);

        // Aligned token: exact cycle timing
        base_d = done_cnt;
        send_token('h1000, 8192, 1'b0);
        chk("al_valid1", rd_if.valid, 1);
        chk("al_addr1", rd_if.vaddr, 'h1000);
        chk("al_size1", rd_if.size, 4096);
        chk("al_link_ready1", link_if.ready, 0);
        tick();
        chk("al_valid2", rd_if.valid, 1);
        chk("al_addr2", rd_if.vaddr, 'h2000);
        chk("al_size2", rd_if.size, 4096);
        tick();
        chk("al_valid_end", rd_if.valid, 0);
        chk("al_link_ready_end", link_if.ready, 1);
        chk("al_busy_end", busy, 0);
        chk("al_done_end", done, 0);
        tick();
        chk("al_no_done", done_cnt - base_d, 0);

        // Unaligned last token: done one cycle after third handshake
        send_token('h0F00, 'h1200, 1'b1);
        chk("un_addr1", rd_if.vaddr, 'h0F00);
        chk("un_size1", rd_if.size, 256);
        tick();
        chk("un_addr2", rd_if.vaddr, 'h1000);
        chk("un_size2", rd_if.size, 4096);
        tick();
        chk("un_addr3", rd_if.vaddr, 'h2000);
        chk("un_size3", rd_if.size, 256);
        chk("un_done_early", done, 0);
        tick();
        chk("un_done", done, 1);
        chk("un_link_ready", link_if.ready, 1);
        tick();
        chk("un_done_once", done, 0);

        // Backpressure on chunk 2
        base_q = mon_q.size();
        send_token('h4000, 12288, 1'b0);
        tick();
        rd_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rd_if.valid, 1);
            chk("bp_addr", rd_if.vaddr, 'h5000);
            chk("bp_size", rd_if.size, 4096);
            chk("bp_link_ready", link_if.ready, 0);
            tick();
        end
        rd_if.ready = 1'b1;
        wait_idle();
        chk("bp_count", mon_q.size() - base_q, 3);
        if (mon_q.size() - base_q == 3) begin
            chk("bp_c0", mon_q[base_q].a, 'h4000);
            chk("bp_c1", mon_q[base_q+1].a, 'h5000);
            chk("bp_c2", mon_q[base_q+2].a, 'h6000);
        end

        // Zero-size last token
        base_q = mon_q.size();
        send_token('h5000, 0, 1'b1);
        chk("z_done", done, 1);
        chk("z_rd_valid", rd_if.valid, 0);
        chk("z_link_ready", link_if.ready, 1);
        tick();
        chk("z_done_once", done, 0);
        chk("z_no_req", mon_q.size() - base_q, 0);

        // Reset during second chunk of a 16 KiB token
        base_d = done_cnt;
        send_token('h10000, 16384, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mr_rd_valid", rd_if.valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_link_ready", link_if.ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_no_done", done_cnt - base_d, 0);
        base_q = mon_q.size();
        base_d = done_cnt;
        send_token('h8000, 64, 1'b1);
        wait_idle();
        chk("mr_count", mon_q.size() - base_q, 1);
        if (mon_q.size() - base_q == 1) begin
            chk("mr_addr", mon_q[base_q].a, 'h8000);
            chk("mr_size", mon_q[base_q].s, 64);
        end
        chk("mr_done_cnt", done_cnt - base_d, 1);

        // Table vectors
        foreach (vecs[i]) begin
            base_q = mon_q.size();
            base_d = done_cnt;
            send_token(vecs[i].va, vecs[i].sz, vecs[i].lst);
            wait_idle();
            chk($sformatf("vec%0d_n", i), mon_q.size() - base_q, vecs[i].n);
            if (vecs[i].n > 0 && mon_q.size() - base_q == vecs[i].n) begin
                chk($sformatf("vec%0d_addr0", i), mon_q[base_q].a, vecs[i].va);
                chk($sformatf("vec%0d_first", i), mon_q[base_q].s, vecs[i].first_sz);
                chk($sformatf("vec%0d_last", i), mon_q[mon_q.size()-1].s, vecs[i].last_sz);
            end
            chk($sformatf("vec%0d_done", i), done_cnt - base_d, vecs[i].dones);
        end

        // Random tokens against a region-splitting model
        base_q   = mon_q.size();
        base_d   = done_cnt;
        exp_done = 0;
        rand_rdy = 1'b1;
        for (int t = 0; t < 30; t++) begin
            longint unsigned va, sz;
            logic lst;
            va  = longint'($urandom);
            if ($urandom_range(0, 3) == 0)
                va = va & ~longint'(MAXB - 1);
            sz  = longint'($urandom_range(0, 65536));
            lst = 1'($urandom_range(0, 1));
            a = va;
            r = sz;
            while (r > 0) begin
                bnd = (a / MAXB + 1) * MAXB;
                c   = (bnd - a < r) ? (bnd - a) : r;
                exp_q.push_back('{a: a, s: c});
                a = a + c;
                r = r - c;
            end
            if (lst)
                exp_done++;
            send_token(va, sz, lst);
        end
        wait_idle();
        rand_rdy    = 1'b0;
        rd_if.ready = 1'b1;
        chk("rnd_count", mon_q.size() - base_q, exp_q.size());
        if (mon_q.size() - base_q == exp_q.size()) begin
            foreach (exp_q[i]) begin
                chk($sformatf("rnd_addr%0d", i), mon_q[base_q+i].a, exp_q[i].a);
                chk($sformatf("rnd_size%0d", i), mon_q[base_q+i].s, exp_q[i].s);
                chk($sformatf("rnd_cross%0d", i),
                    ((mon_q[base_q+i].a % MAXB) + mon_q[base_q+i].s <= MAXB) ? 1 : 0, 1);
            end
        end
        chk("rnd_done", done_cnt - base_d, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
